// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg
// Shared definitions for the HI/LO multiply/divide unit: ALU op encodings
// (MIPS funct values) and muldiv sequencer states. Also holds the divide
// step count and a few small decode helpers.
package muldiv_ctrl_pkg;

    localparam logic [5:0] ALU_MFHI  = 6'h10;
    localparam logic [5:0] ALU_MTHI  = 6'h11;
    localparam logic [5:0] ALU_MFLO  = 6'h12;
    localparam logic [5:0] ALU_MTLO  = 6'h13;
    localparam logic [5:0] ALU_MULT  = 6'h18;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_DIV   = 6'h1A;
    localparam logic [5:0] ALU_DIVU  = 6'h1B;

    localparam int unsigned MD_DIV_STEPS = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic op_is_mul(input logic [5:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [5:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [5:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV);
    endfunction

    // Magnitude of v when it is treated as signed. Otherwise v is returned unchanged.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if
// EX-stage connection to the muldiv unit.
//   op_valid, alu_op, src_a, src_b, flush : pipeline -> muldiv
//   stall_req, hi, lo, rd_data            : muldiv -> pipeline
// The master modport is for the pipeline side. The slave modport is for muldiv_ctrl.
interface muldiv_ctrl_if;
    logic        op_valid;
    logic [5:0]  alu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    modport master (
        output op_valid, alu_op, src_a, src_b, flush,
        input  stall_req, hi, lo, rd_data
    );

    modport slave (
        input  op_valid, alu_op, src_a, src_b, flush,
        output stall_req, hi, lo, rd_data
    );
endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// div_iter
// Unsigned 32-bit radix-2 restoring divider. It performs one quotient bit per cycle.
// Ports:
//   clk, rst (sync, active-high)
//   start_i      : load dividend/divisor. Steps run on the next MD_DIV_STEPS cycles.
//   abort_i      : drop the operation in flight
//   dividend_i, divisor_i
//   done_o       : high during the final step cycle
//   quotient_o, remainder_o : values after this cycle's step. They are valid while done_o is high.
module div_iter
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic        busy_q, busy_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;

    logic [32:0] rem_shift;
    logic        ge;
    logic [31:0] sub;

    always_comb begin
        rem_shift = {rem_q, quo_q[31]};
        ge        = rem_shift >= {1'b0, dvs_q};
        // When ge holds, the true difference is below the divisor. Modulo-2^32 subtraction therefore gives it exactly.
        sub       = rem_shift[31:0] - dvs_q;

        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;

        if (abort_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = 5'(MD_DIV_STEPS - 1);
            rem_d  = '0;
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
        end else if (busy_q) begin
            rem_d = ge ? sub : rem_shift[31:0];
            quo_d = {quo_q[30:0], ge};
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
                busy_d = 1'b0;
            end
        end
    end

    assign done_o      = busy_q & ~abort_i & (cnt_q == 5'd0);
    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// EX-stage multiply/divide sequencer. It owns the architectural HI/LO pair.
// Multiplies complete after a fixed latency of MUL_LAT cycles. Divides are iterative (div_iter).
// HI/LO are written from the result registers in the DONE cycle, unless that cycle is flushed.
// Ports:
//   clk, rst (sync, active-high)
//   bus : muldiv_ctrl_if.slave. It carries op_valid/alu_op/src_a/src_b/flush in, and stall_req/hi/lo/rd_data out.
//
// state   | meaning
// IDLE    | accepting MT*/MF* and new mul/div starts
// MUL     | multiply latency countdown
// DIV     | div_iter running 32 steps
// DONE    | result ready; commit HI/LO unless flushed
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    md_state_e   state_q, state_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic        sgn_q, sgn_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_mul, is_div, is_sgn, start, div_zero;
    logic [31:0] mul_a, mul_b;
    logic        mul_sgn;
    logic [63:0] product;
    logic        div_start, div_abort, div_done;
    logic [31:0] div_quo, div_rem;

    assign is_mul   = op_is_mul(bus.alu_op);
    assign is_div   = op_is_div(bus.alu_op);
    assign is_sgn   = op_is_signed(bus.alu_op);
    assign div_zero = (bus.src_b == 32'd0);
    assign start    = (state_q == MD_IDLE) & bus.op_valid & ~bus.flush & (is_mul | is_div);

    // Use the live operands in IDLE so that MUL_LAT=1 can finish directly from the start cycle.
    assign mul_a   = (state_q == MD_IDLE) ? bus.src_a : op_a_q;
    assign mul_b   = (state_q == MD_IDLE) ? bus.src_b : op_b_q;
    assign mul_sgn = (state_q == MD_IDLE) ? is_sgn    : sgn_q;
    // Sign-extend to 64 bits. The truncated 64x64 product is then correct for both signed and unsigned operands.
    assign product = {{32{mul_sgn & mul_a[31]}}, mul_a} * {{32{mul_sgn & mul_b[31]}}, mul_b};

    assign div_start = start & is_div & ~div_zero;
    assign div_abort = (state_q == MD_DIV) & bus.flush;

    div_iter u_div_iter (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_start),
        .abort_i     (div_abort),
        .dividend_i  (mag32(bus.src_a, is_sgn)),
        .divisor_i   (mag32(bus.src_b, is_sgn)),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        sgn_d     = sgn_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    op_a_d  = bus.src_a;
                    op_b_d  = bus.src_b;
                    sgn_d   = is_sgn;
                    q_neg_d = is_sgn & (bus.src_a[31] ^ bus.src_b[31]);
                    r_neg_d = is_sgn & bus.src_a[31];
                    if (is_div) begin
                        if (div_zero) begin
                            res_hi_d = bus.src_a;
                            res_lo_d = 32'hFFFF_FFFF;
                            state_d  = MD_DONE;
                        end else begin
                            state_d = MD_DIV;
                        end
                    end else if (MUL_LAT <= 1) begin
                        {res_hi_d, res_lo_d} = product;
                        state_d = MD_DONE;
                    end else begin
                        mul_cnt_d = CNT_W'(MUL_LAT - 1);
                        state_d   = MD_MUL;
                    end
                end else if (bus.op_valid && !bus.flush) begin
                    if (bus.alu_op == ALU_MTHI) hi_d = bus.src_a;
                    if (bus.alu_op == ALU_MTLO) lo_d = bus.src_a;
                end
            end
            MD_MUL: begin
                // The counter is loaded with MUL_LAT-1 and reaches 0 on the edge into DONE.
                if (bus.flush) begin
                    state_d = MD_IDLE;
                end else if (mul_cnt_q == CNT_W'(1)) begin
                    {res_hi_d, res_lo_d} = product;
                    mul_cnt_d = '0;
                    state_d   = MD_DONE;
                end else begin
                    mul_cnt_d = mul_cnt_q - CNT_W'(1);
                end
            end
            MD_DIV: begin
                if (bus.flush) begin
                    state_d = MD_IDLE;
                end else if (div_done) begin
                    res_lo_d = q_neg_q ? (~div_quo + 32'd1) : div_quo;
                    res_hi_d = r_neg_q ? (~div_rem + 32'd1) : div_rem;
                    state_d  = MD_DONE;
                end
            end
            MD_DONE: begin
                if (!bus.flush) begin
                    hi_d = res_hi_q;
                    lo_d = res_lo_q;
                end
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            mul_cnt_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            sgn_q     <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            sgn_q     <= sgn_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.stall_req = start |
                           (((state_q == MD_MUL) || (state_q == MD_DIV)) & ~bus.flush);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.rd_data   = (bus.alu_op == ALU_MFHI) ? hi_q :
                           (bus.alu_op == ALU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_ctrl_if md_if ();

    muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (md_if.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          stalls;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic fl);
        md_if.op_valid = v;
        md_if.alu_op   = op;
        md_if.src_a    = a;
        md_if.src_b    = b;
        md_if.flush    = fl;
    endtask

    // Called just after a negedge. It holds the op until stall_req drops, which marks the DONE cycle.
    // It then returns at the negedge of the following cycle.
    task automatic run_muldiv(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                              output int stalls, output bit timeout);
        bit seen_done;
        stalls    = 0;
        seen_done = 1'b0;
        drive(1'b1, op, a, b, 1'b0);
        for (int i = 0; i < 100 && !seen_done; i++) begin
            #1;
            if (md_if.stall_req) begin
                stalls++;
                @(negedge clk);
            end else begin
                seen_done = 1'b1;
            end
        end
        timeout = !seen_done;
        @(negedge clk);
    endtask

    initial begin
        int  stalls;
        bit  to;

        vecs[0]  = '{ALU_MULT,  32'hFFFFFFFD, 32'h00000005, 2,  32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 2,  32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{ALU_DIV,   32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{ALU_DIVU,  32'h00000064, 32'h00000000, 1,  32'h00000064, 32'hFFFFFFFF};
        vecs[4]  = '{ALU_DIVU,  32'h00000064, 32'h00000003, 33, 32'h00000001, 32'h00000021};
        vecs[5]  = '{ALU_DIV,   32'h00000007, 32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD};
        vecs[6]  = '{ALU_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 33, 32'hFFFFFFFE, 32'h00000002};
        vecs[7]  = '{ALU_MULT,  32'h80000000, 32'h80000000, 2,  32'h40000000, 32'h00000000};
        vecs[8]  = '{ALU_MULTU, 32'h80000000, 32'h00000002, 2,  32'h00000001, 32'h00000000};
        vecs[9]  = '{ALU_DIV,   32'hFFFFFFF9, 32'h00000000, 1,  32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[10] = '{ALU_DIVU,  32'hFFFFFFFF, 32'h00000001, 33, 32'h00000000, 32'hFFFFFFFF};
        vecs[11] = '{ALU_MULT,  32'hFFFFFFFF, 32'h00000001, 2,  32'hFFFFFFFF, 32'hFFFFFFFF};

        rst = 1'b1;
        drive(1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", {31'b0, md_if.stall_req}, 32'd0);
        chk("rst_hi", md_if.hi, 32'd0);
        chk("rst_lo", md_if.lo, 32'd0);
        chk("rst_rd", md_if.rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors. After each DONE, MFLO and then MFHI read the result back through rd_data.
        for (int v = 0; v < 12; v++) begin
            run_muldiv(vecs[v].op, vecs[v].a, vecs[v].b, stalls, to);
            if (to) begin
                checks++;
                failures++;
                $display("FAIL vec%0d_timeout: stall_req never dropped", v);
            end
            chk($sformatf("vec%0d_stalls", v), 32'(stalls), 32'(vecs[v].stalls));
            drive(1'b1, ALU_MFLO, 32'h0, 32'h0, 1'b0);
            #1;
            chk($sformatf("vec%0d_hi", v), md_if.hi, vecs[v].hi);
            chk($sformatf("vec%0d_lo", v), md_if.lo, vecs[v].lo);
            chk($sformatf("vec%0d_mflo", v), md_if.rd_data, vecs[v].lo);
            @(negedge clk);
            drive(1'b1, ALU_MFHI, 32'h0, 32'h0, 1'b0);
            #1;
            chk($sformatf("vec%0d_mfhi", v), md_if.rd_data, vecs[v].hi);
            chk($sformatf("vec%0d_mf_stall", v), {31'b0, md_if.stall_req}, 32'd0);
            @(negedge clk);
        end

        // Flush in the middle of DIVU: HI/LO are left unchanged, and a following MTLO is accepted.
        drive(1'b1, ALU_MTHI, 32'h0000AAAA, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, ALU_MTLO, 32'h0000BBBB, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, ALU_DIVU, 32'd100, 32'd3, 1'b0);
        #1;
        chk("flush_div_start_stall", {31'b0, md_if.stall_req}, 32'd1);
        repeat (10) @(negedge clk);
        md_if.flush = 1'b1;
        #1;
        chk("flush_div_stall", {31'b0, md_if.stall_req}, 32'd0);
        @(negedge clk);
        drive(1'b1, ALU_MTLO, 32'd5, 32'h0, 1'b0);
        #1;
        chk("flush_mtlo_stall", {31'b0, md_if.stall_req}, 32'd0);
        @(negedge clk);
        drive(1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
        #1;
        chk("flush_hi", md_if.hi, 32'h0000AAAA);
        chk("flush_lo", md_if.lo, 32'd5);
        repeat (40) @(negedge clk);
        #1;
        chk("flush_late_hi", md_if.hi, 32'h0000AAAA);
        chk("flush_late_lo", md_if.lo, 32'd5);
        @(negedge clk);

        // A flush in the DONE cycle discards the multiply result.
        drive(1'b1, ALU_MULT, 32'd2, 32'd3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        md_if.flush = 1'b1;
        #1;
        chk("done_flush_stall", {31'b0, md_if.stall_req}, 32'd0);
        @(negedge clk);
        drive(1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
        #1;
        chk("done_flush_hi", md_if.hi, 32'h0000AAAA);
        chk("done_flush_lo", md_if.lo, 32'd5);
        @(negedge clk);

        // A flush in IDLE: MULT does not start and nothing is written.
        drive(1'b1, ALU_MULT, 32'd4, 32'd4, 1'b1);
        #1;
        chk("idle_flush_stall", {31'b0, md_if.stall_req}, 32'd0);
        @(negedge clk);
        drive(1'b1, ALU_MTHI, 32'hDEAD0000, 32'h0, 1'b1);
        #1;
        chk("idle_flush2_stall", {31'b0, md_if.stall_req}, 32'd0);
        @(negedge clk);
        drive(1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("idle_flush_hi", md_if.hi, 32'h0000AAAA);
        chk("idle_flush_lo", md_if.lo, 32'd5);
        @(negedge clk);

        // MTHI followed by MFHI in the next cycle.
        drive(1'b1, ALU_MTHI, 32'h00001234, 32'h0, 1'b0);
        #1;
        chk("mthi_stall", {31'b0, md_if.stall_req}, 32'd0);
        @(negedge clk);
        drive(1'b1, ALU_MFHI, 32'h0, 32'h0, 1'b0);
        #1;
        chk("mfhi_rd", md_if.rd_data, 32'h00001234);
        chk("mfhi_stall", {31'b0, md_if.stall_req}, 32'd0);
        @(negedge clk);

        // Reset in the middle of DIV.
        drive(1'b1, ALU_DIV, 32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_stall", {31'b0, md_if.stall_req}, 32'd0);
        chk("midrst_hi", md_if.hi, 32'd0);
        chk("midrst_lo", md_if.lo, 32'd0);
        @(negedge clk);
        run_muldiv(ALU_DIVU, 32'd100, 32'd3, stalls, to);
        if (to) begin
            checks++;
            failures++;
            $display("FAIL postrst_timeout: stall_req never dropped");
        end
        chk("postrst_stalls", 32'(stalls), 32'd33);
        drive(1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
        #1;
        chk("postrst_hi", md_if.hi, 32'd1);
        chk("postrst_lo", md_if.lo, 32'd33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
